// File: rtl/fitness_eval.sv
// Sweeps every input pattern through the phenotype circuit and counts mismatching output bits.
// Optional early abort (fitness forced to all-ones) is built when EARLY_ABORT_EN is defined.
module fitness_eval #(
    parameter int         primaryInputCount  = 8,
    parameter int         geneResultBit      = 2,
    parameter int         evalLatency        = 1,
    parameter logic [2:0] fitness_controller = 3'b001,
    parameter int         abortLimit         = 16
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [2:0]                   state_controller,
    input  logic                         geneReady,
    input  logic [geneResultBit-1:0]     circuitOut,
    input  logic [geneResultBit-1:0]     targetIn,
    output logic [primaryInputCount-1:0] patternOut,
    output logic [primaryInputCount+1:0] fitness,
    output logic                         fitnessReady,
    output logic                         busy,
    output logic [2:0]                   o_dbg_state
);

    localparam int FW = primaryInputCount + 2;
    localparam int SW = FW + 1;
    localparam int PW = $clog2(geneResultBit + 1);
    localparam int WW = $clog2(evalLatency + 1);

`ifdef EARLY_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                      r_state;
    logic [primaryInputCount-1:0] r_patternOut;
    logic [FW-1:0]               r_fitness;
    logic                        r_fitnessReady;
    logic                        r_busy;
    logic [FW-1:0]               r_errCount;
    logic [WW-1:0]               r_waitCnt;

    logic                        w_enabled;
    logic [PW-1:0]               w_pop;
    logic [SW-1:0]               w_sum;
    logic [FW-1:0]               w_sat;
    logic                        w_last;
    logic                        w_abort;

    function automatic logic [PW-1:0] popcount(input logic [geneResultBit-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < geneResultBit; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    assign w_enabled = (state_controller == fitness_controller);
    assign w_pop     = popcount(circuitOut ^ targetIn);
    assign w_sum     = {1'b0, r_errCount} + SW'(w_pop);
    // The count sticks at all-ones rather than wrapping past the top.
    assign w_sat     = w_sum[FW] ? {FW{1'b1}} : w_sum[FW-1:0];
    assign w_last    = (r_patternOut == {primaryInputCount{1'b1}});
    assign w_abort   = ABORT_EN && (int'(w_sat) > abortLimit);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_patternOut   <= '0;
            r_fitness      <= '0;
            r_fitnessReady <= 1'b0;
            r_busy         <= 1'b0;
            r_errCount     <= '0;
            r_waitCnt      <= '0;
        end else if (!w_enabled) begin
            // Losing the enable abandons the sweep; no partial result is published.
            r_state        <= IDLE;
            r_patternOut   <= '0;
            r_fitnessReady <= 1'b0;
            r_busy         <= 1'b0;
            r_errCount     <= '0;
            r_waitCnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (geneReady) begin
                        r_state      <= DRIVE;
                        r_patternOut <= '0;
                        r_errCount   <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                DRIVE: begin
                    r_waitCnt <= WW'(evalLatency);
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (r_waitCnt <= WW'(1)) begin
                        r_waitCnt <= '0;
                        r_state   <= SAMPLE;
                    end else begin
                        r_waitCnt <= r_waitCnt - WW'(1);
                    end
                end
                SAMPLE: begin
                    r_errCount <= w_sat;
                    if (w_abort) begin
                        r_fitness      <= {FW{1'b1}};
                        r_fitnessReady <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= DONE;
                    end else if (w_last) begin
                        r_fitness      <= w_sat;
                        r_fitnessReady <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= DONE;
                    end else begin
                        r_patternOut <= r_patternOut + 1'b1;
                        r_state      <= DRIVE;
                    end
                end
                DONE: begin
                    if (!geneReady) begin
                        r_fitnessReady <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign patternOut   = r_patternOut;
    assign fitness      = r_fitness;
    assign fitnessReady = r_fitnessReady;
    assign busy         = r_busy;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fitness_eval.sv
// Bench for fitness_eval with a 2-input, 2-output phenotype modelled as lookup tables behind a latency pipe.
// Builds with or without EARLY_ABORT_EN; expectations follow the macro.
module tb_fitness_eval;

    localparam logic [2:0] EN  = 3'b001;
    localparam int         LIM = 3;
`ifdef EARLY_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] sc1, sc3;
    logic       gr1, gr3;
    logic [1:0] co1, ti1, co3, ti3, po1, po3;
    logic [3:0] fit1, fit3;
    logic       fr1, fr3, busy1, busy3;
    logic [2:0] st1, st3;
    logic [7:0] circ1, tgt1, circ3, tgt3;
    logic [1:0] d1;
    logic [1:0] d3 [3];

    int n_tests = 0;
    int n_fail  = 0;

    fitness_eval #(.primaryInputCount(2), .geneResultBit(2), .evalLatency(1),
                   .fitness_controller(EN), .abortLimit(LIM)) dut1 (
        .CLOCK_50(clk), .reset(rst), .state_controller(sc1), .geneReady(gr1),
        .circuitOut(co1), .targetIn(ti1), .patternOut(po1), .fitness(fit1),
        .fitnessReady(fr1), .busy(busy1), .o_dbg_state(st1));

    fitness_eval #(.primaryInputCount(2), .geneResultBit(2), .evalLatency(3),
                   .fitness_controller(EN), .abortLimit(16)) dut3 (
        .CLOCK_50(clk), .reset(rst), .state_controller(sc3), .geneReady(gr3),
        .circuitOut(co3), .targetIn(ti3), .patternOut(po3), .fitness(fit3),
        .fitnessReady(fr3), .busy(busy3), .o_dbg_state(st3));

    // Phenotype outputs only reflect a new pattern after the circuit's latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d1    <= '0;
            d3[0] <= '0;
            d3[1] <= '0;
            d3[2] <= '0;
        end else begin
            d1    <= po1;
            d3[0] <= po3;
            d3[1] <= d3[0];
            d3[2] <= d3[1];
        end
    end
    assign co1 = circ1[{d1, 1'b0} +: 2];
    assign ti1 = tgt1[{d1, 1'b0} +: 2];
    assign co3 = circ3[{d3[2], 1'b0} +: 2];
    assign ti3 = tgt3[{d3[2], 1'b0} +: 2];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: total mismatching bits over all rows, abort once the running total passes the limit.
    task automatic ref_model(input logic [7:0] c, input logic [7:0] t, input int lat, input int lim,
                             output logic [3:0] f, output int edges);
        int acc;
        acc   = 0;
        f     = 4'h0;
        edges = 4 * (lat + 2);
        for (int p = 0; p < 4; p++) begin
            acc += $countones(c[2*p +: 2] ^ t[2*p +: 2]);
            if (ABORT_EN && acc > lim) begin
                f     = 4'hF;
                edges = (p + 1) * (lat + 2);
                return;
            end
        end
        f = 4'(acc);
    endtask

    task automatic sample(input int which, output logic r, output logic b,
                          output logic [1:0] p, output logic [3:0] f);
        if (which == 3) begin
            r = fr3; b = busy3; p = po3; f = fit3;
        end else begin
            r = fr1; b = busy1; p = po1; f = fit1;
        end
    endtask

    task automatic run_sweep(input int which, input logic [7:0] c, input logic [7:0] t,
                             input logic [3:0] ef, input int ee, input string nm);
        int n, seq, last, lat, k, es;
        bit held;
        logic r, b;
        logic [1:0] p;
        logic [3:0] f;
        lat = (which == 3) ? 3 : 1;
        if (which == 3) begin
            circ3 = c; tgt3 = t; sc3 = EN; gr3 = 1'b1;
        end else begin
            circ1 = c; tgt1 = t; sc1 = EN; gr1 = 1'b1;
        end
        n = -1; seq = 0; last = -1; r = 1'b0;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            sample(which, r, b, p, f);
            if (b && int'(p) != last) begin
                seq  = seq * 10 + int'(p) + 1;
                last = int'(p);
            end
            if (r) break;
        end
        k  = ee / (lat + 2);
        es = 0;
        for (int i = 0; i < k; i++) es = es * 10 + i + 1;
        check({nm, "_ready_edge"}, n, ee);
        check({nm, "_fitness"}, int'(f), int'(ef));
        check({nm, "_pattern_seq"}, seq, es);
        check({nm, "_busy_at_done"}, int'(b), 0);
        held = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            sample(which, r, b, p, f);
            if (!r || f != ef) held = 1'b0;
        end
        check({nm, "_held"}, int'(held), 1);
        if (which == 3) gr3 = 1'b0; else gr1 = 1'b0;
        @(posedge clk); #1;
        sample(which, r, b, p, f);
        check({nm, "_ready_drop"}, int'(r), 0);
        check({nm, "_fitness_kept"}, int'(f), int'(ef));
    endtask

    typedef struct {
        logic [7:0] c;
        logic [7:0] t;
        logic [3:0] fit_full;
        int         edges_full;
        logic [3:0] fit_abort;
        int         edges_abort;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0] rc, rt;
        logic [3:0] ef;
        int ee;
        bit ok;

        vecs[0] = '{8'hE4, 8'hE4, 4'd0, 12, 4'd0,  12};
        vecs[1] = '{8'hFF, 8'h00, 4'd8, 12, 4'hF,  6};
        vecs[2] = '{8'h10, 8'h20, 4'd2, 12, 4'd2,  12};
        vecs[3] = '{8'h01, 8'h00, 4'd1, 12, 4'd1,  12};
        vecs[4] = '{8'h55, 8'hAA, 4'd8, 12, 4'hF,  6};
        vecs[5] = '{8'hC0, 8'h00, 4'd2, 12, 4'd2,  12};
        vecs[6] = '{8'h0F, 8'h00, 4'd4, 12, 4'hF,  6};
        vecs[7] = '{8'h07, 8'h00, 4'd3, 12, 4'd3,  12};

        sc1 = EN; sc3 = EN; gr1 = 1'b0; gr3 = 1'b0;
        circ1 = '0; tgt1 = '0; circ3 = '0; tgt3 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pattern", int'(po1), 0);
        check("rst_fitness", int'(fit1), 0);
        check("rst_ready", int'(fr1), 0);
        check("rst_busy", int'(busy1), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_gene", int'(busy1), 0);

        for (int i = 0; i < 8; i++) begin
            run_sweep(1, vecs[i].c, vecs[i].t,
                      ABORT_EN ? vecs[i].fit_abort : vecs[i].fit_full,
                      ABORT_EN ? vecs[i].edges_abort : vecs[i].edges_full,
                      $sformatf("vec%0d", i));
        end

        run_sweep(3, 8'h10, 8'h20, 4'd2, 20, "lat3");

        // Asynchronous reset while the second pattern is in WAIT.
        circ1 = 8'h00; tgt1 = 8'h00; sc1 = EN; gr1 = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        check("arst_pre_state", {30'd0, busy1, po1 == 2'd1}, 3);
        #1 rst = 1'b1;
        #1;
        check("arst_pattern", int'(po1), 0);
        check("arst_fitness", int'(fit1), 0);
        check("arst_ready", int'(fr1), 0);
        check("arst_busy", int'(busy1), 0);
        #3 rst = 1'b0;
        gr1 = 1'b0;
        @(posedge clk); #1;
        check("arst_idle", int'(busy1), 0);

        // Enable dropped during pattern 1, then a clean sweep after re-enable.
        circ1 = 8'h00; tgt1 = 8'h00; sc1 = EN; gr1 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (po1 == 2'd1) break;
        end
        check("dis_reached_p1", int'(po1), 1);
        sc1 = 3'b010;
        @(posedge clk); #1;
        check("dis_busy", int'(busy1), 0);
        check("dis_pattern", int'(po1), 0);
        check("dis_ready", int'(fr1), 0);
        ok = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (fr1 || busy1) ok = 1'b0;
        end
        check("dis_stays_idle", int'(ok), 1);
        run_sweep(1, 8'h01, 8'h00, 4'd1, 12, "reenable");

        for (int i = 0; i < 20; i++) begin
            rc = 8'($urandom);
            if (i % 2 == 0) rt = rc ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            else rt = 8'($urandom);
            ref_model(rc, rt, 1, LIM, ef, ee);
            run_sweep(1, rc, rt, ef, ee, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
